// File: rtl/platformniostimer_loader_pkg.sv
// Shared types and constants for the on-chip RAM image loader.
//   state_t        : loader FSM states
//   LANES          : byte lanes per RAM word
//   BE_FULL        : byteenable with every lane active
//   WORD_MASK_FULL : data mask with every bit active
//   be_to_mask()   : expands a 4-bit byteenable into a 32-bit data mask
package platformniostimer_loader_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_WRITE,
        S_DRAIN,
        S_VERIFY_RD,
        S_VERIFY_WAIT,
        S_DONE
    } state_t;

    localparam int LANES = 4;
    localparam logic [LANES-1:0] BE_FULL = 4'hF;
    localparam logic [31:0] WORD_MASK_FULL = 32'hFFFF_FFFF;

    function automatic logic [31:0] be_to_mask(input logic [LANES-1:0] be);
        logic [31:0] m;
        m = '0;
        for (int i = 0; i < LANES; i++) begin
            m[i*8 +: 8] = {8{be[i]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/platformniostimer_loader_packer.sv
// Little-endian byte packer: collects stream bytes into a 32-bit word.
//   clk, reset  : clock, asynchronous active-high reset
//   clear       : empty the word (combined with accept, the byte lands in lane 0)
//   accept      : a byte is taken this cycle
//   byte_data   : the byte being taken
//   word        : packed word, unfilled lanes read as 0
//   byteenable  : one bit per filled lane
//   lane        : lane the next accepted byte goes to
module platformniostimer_loader_packer
    import platformniostimer_loader_pkg::*;
(
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clear,
    input  logic                       accept,
    input  logic [7:0]                 byte_data,
    output logic [31:0]                word,
    output logic [LANES-1:0]           byteenable,
    output logic [$clog2(LANES)-1:0]   lane
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            word       <= '0;
            byteenable <= '0;
            lane       <= '0;
        end else if (clear) begin
            // A clear that coincides with an accepted byte starts a fresh word
            // with that byte already in lane 0.
            word       <= accept ? {24'h0, byte_data} : 32'h0;
            byteenable <= accept ? 4'b0001 : 4'b0000;
            lane       <= accept ? 2'd1 : 2'd0;
        end else if (accept) begin
            word[{lane, 3'b000} +: 8] <= byte_data;
            byteenable[lane]          <= 1'b1;
            lane                      <= lane + 2'd1;
        end
    end

endmodule

// File: rtl/platformniostimer_onchip_loader.sv
// Streams an 8-bit Avalon-ST packet into on-chip RAM as little-endian
// 32-bit words at sequential addresses from BASE_ADDR, then optionally reads
// the region back and compares an XOR checksum.
//   clk, reset          : clock, asynchronous active-high reset
//   in_*                : Avalon-ST byte sink (data/valid/sop/eop/ready)
//   mem_*               : RAM s1 master side; mem_readdata is valid one cycle
//                         after the address
//   busy                : any state other than IDLE
//   done                : one-cycle pulse at packet completion
//   err_overflow        : packet did not fit between BASE_ADDR and DEPTH
//   err_verify          : readback checksum differed from written checksum
//   err_framing         : SOP arrived inside a partially filled word
//   word_count          : words written for the current or last packet
module platformniostimer_onchip_loader
    import platformniostimer_loader_pkg::*;
#(
    parameter int ADDR_W    = 13,
    parameter int DEPTH     = 8192,
    parameter int BASE_ADDR = 0,
    parameter int VERIFY_EN = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    input  logic              in_startofpacket,
    input  logic              in_endofpacket,
    output logic              in_ready,
    output logic [ADDR_W-1:0] mem_address,
    output logic [3:0]        mem_byteenable,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [31:0]       mem_writedata,
    input  logic [31:0]       mem_readdata,
    output logic              busy,
    output logic              done,
    output logic              err_overflow,
    output logic              err_verify,
    output logic              err_framing,
    output logic [ADDR_W:0]   word_count
);

    // Number of words that fit between BASE_ADDR and the top of the RAM.
    localparam logic [ADDR_W:0] LIMIT     = (ADDR_W+1)'(DEPTH - BASE_ADDR);
    localparam logic [1:0]      LAST_LANE = 2'(LANES - 1);

    state_t state, state_n;

    logic              pk_clear, pk_accept;
    logic [31:0]       pk_word;
    logic [LANES-1:0]  pk_be;
    logic [1:0]        pk_lane;

    logic              start, restart;
    logic              last_q;
    logic [ADDR_W:0]   vidx;
    logic [31:0]       checksum, vsum, vsum_n;
    logic [LANES-1:0]  last_be;
    logic              wc_full, vidx_last;
    logic [ADDR_W:0]   wc_n, vidx_n;

    platformniostimer_loader_packer u_packer (
        .clk        (clk),
        .reset      (reset),
        .clear      (pk_clear),
        .accept     (pk_accept),
        .byte_data  (in_data),
        .word       (pk_word),
        .byteenable (pk_be),
        .lane       (pk_lane)
    );

    assign wc_full   = (word_count == LIMIT);
    assign vidx_last = (vidx == word_count - 1'b1);
    assign busy      = (state != S_IDLE);

    // Address counters as they will stand in the next cycle; used to
    // register the RAM address one cycle ahead of the strobe.
    assign wc_n   = start ? '0 : word_count;
    assign vidx_n = (state == S_WRITE) ? '0 : vidx + 1'b1;

    assign vsum_n = vsum ^ (mem_readdata &
                            (vidx_last ? be_to_mask(last_be) : WORD_MASK_FULL));

    // Write data and lanes come straight from the packer register while the
    // registered write strobe is up; reads enable every lane.
    assign mem_writedata  = mem_write ? pk_word : 32'h0;
    assign mem_byteenable = mem_write ? pk_be : (mem_chipselect ? BE_FULL : 4'h0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n   = state;
        in_ready  = 1'b0;
        pk_clear  = 1'b0;
        pk_accept = 1'b0;
        start     = 1'b0;
        restart   = 1'b0;
        case (state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid && in_startofpacket) begin
                    start     = 1'b1;
                    pk_clear  = 1'b1;
                    pk_accept = 1'b1;
                    state_n   = in_endofpacket ? S_WRITE : S_FILL;
                end
            end
            S_FILL: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    pk_accept = 1'b1;
                    if (in_startofpacket) begin
                        // Framing error: drop the partial word, restart at BASE_ADDR.
                        start    = 1'b1;
                        restart  = 1'b1;
                        pk_clear = 1'b1;
                        state_n  = in_endofpacket ? S_WRITE : S_FILL;
                    end else if (in_endofpacket || pk_lane == LAST_LANE) begin
                        state_n = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                pk_clear = 1'b1;
                if (wc_full) begin
                    state_n = last_q ? S_DONE : S_DRAIN;
                end else if (!last_q) begin
                    state_n = S_FILL;
                end else if (VERIFY_EN != 0) begin
                    state_n = S_VERIFY_RD;
                end else begin
                    state_n = S_DONE;
                end
            end
            S_DRAIN: begin
                in_ready = 1'b1;
                if (in_valid && in_endofpacket) begin
                    state_n = S_DONE;
                end
            end
            S_VERIFY_RD:   state_n = S_VERIFY_WAIT;
            S_VERIFY_WAIT: state_n = vidx_last ? S_DONE : S_VERIFY_RD;
            S_DONE:        state_n = S_IDLE;
            default:       state_n = S_IDLE;
        endcase
    end

    // RAM strobes, address and done are registered from the next state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_chipselect <= 1'b0;
            mem_write      <= 1'b0;
            mem_address    <= '0;
            done           <= 1'b0;
        end else begin
            mem_write      <= (state_n == S_WRITE) && (wc_n != LIMIT);
            mem_chipselect <= ((state_n == S_WRITE) && (wc_n != LIMIT)) ||
                              (state_n == S_VERIFY_RD);
            if (state_n == S_WRITE) begin
                mem_address <= ADDR_W'(BASE_ADDR) + wc_n[ADDR_W-1:0];
            end else if (state_n == S_VERIFY_RD) begin
                mem_address <= ADDR_W'(BASE_ADDR) + vidx_n[ADDR_W-1:0];
            end else begin
                mem_address <= '0;
            end
            done <= (state_n == S_DONE);
        end
    end

    // Packet control: counters, last-byte tracking and sticky error flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_q       <= 1'b0;
            word_count   <= '0;
            vidx         <= '0;
            err_overflow <= 1'b0;
            err_verify   <= 1'b0;
            err_framing  <= 1'b0;
        end else begin
            if (pk_accept) begin
                last_q <= in_endofpacket;
            end
            if (start) begin
                word_count <= '0;
                if (!restart) begin
                    err_overflow <= 1'b0;
                    err_verify   <= 1'b0;
                    err_framing  <= 1'b0;
                end else begin
                    err_framing <= 1'b1;
                end
            end
            if (state == S_WRITE) begin
                vidx <= '0;
                if (wc_full) begin
                    err_overflow <= 1'b1;
                end else begin
                    word_count <= word_count + 1'b1;
                end
            end
            if (state == S_VERIFY_WAIT) begin
                if (vidx_last) begin
                    err_verify <= (vsum_n != checksum);
                end else begin
                    vidx <= vidx + 1'b1;
                end
            end
        end
    end

    // Checksum datapath: no reset needed, each packet clears it on SOP.
    always_ff @(posedge clk) begin
        if (start) begin
            checksum <= '0;
        end else if (state == S_WRITE && !wc_full) begin
            checksum <= checksum ^ (pk_word & be_to_mask(pk_be));
        end
        if (state == S_WRITE && !wc_full) begin
            last_be <= pk_be;
        end
        if (state == S_WRITE) begin
            vsum <= '0;
        end else if (state == S_VERIFY_WAIT) begin
            vsum <= vsum_n;
        end
    end

endmodule

// File: tb/tb_platformniostimer_onchip_loader.sv
module tb_platformniostimer_onchip_loader;

    localparam int ADDR_W = 3;
    localparam int DEPTH  = 4;
    localparam int BASE   = 0;
    localparam int CAP    = DEPTH - BASE;

    logic              clk = 1'b0;
    logic              reset;
    logic [7:0]        in_data;
    logic              in_valid, in_sop, in_eop;
    logic              in_ready;
    logic [ADDR_W-1:0] mem_address;
    logic [3:0]        mem_byteenable;
    logic              mem_chipselect, mem_write;
    logic [31:0]       mem_writedata, mem_readdata;
    logic              busy, done, err_overflow, err_verify, err_framing;
    logic [ADDR_W:0]   word_count;

    platformniostimer_onchip_loader #(
        .ADDR_W(ADDR_W), .DEPTH(DEPTH), .BASE_ADDR(BASE), .VERIFY_EN(1)
    ) dut (
        .clk(clk), .reset(reset),
        .in_data(in_data), .in_valid(in_valid),
        .in_startofpacket(in_sop), .in_endofpacket(in_eop), .in_ready(in_ready),
        .mem_address(mem_address), .mem_byteenable(mem_byteenable),
        .mem_chipselect(mem_chipselect), .mem_write(mem_write),
        .mem_writedata(mem_writedata), .mem_readdata(mem_readdata),
        .busy(busy), .done(done), .err_overflow(err_overflow),
        .err_verify(err_verify), .err_framing(err_framing), .word_count(word_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct { int addr; logic [31:0] data; logic [3:0] be; } wr_t;
    typedef struct { int wc; bit ovf; bit ver; bit frm; int nrd; } res_t;
    wr_t  wq[$];
    res_t rq[$];

    // RAM model with 1-cycle read latency; flip1 corrupts readback of word 1.
    logic [31:0]       ram [0:(1<<ADDR_W)-1];
    logic [ADDR_W-1:0] rd_addr;
    bit                flip1 = 1'b0;

    always @(posedge clk) begin
        if (mem_chipselect && mem_write) begin
            for (int i = 0; i < 4; i++) begin
                if (mem_byteenable[i]) ram[mem_address][i*8 +: 8] <= mem_writedata[i*8 +: 8];
            end
        end
        rd_addr <= mem_address;
    end
    assign mem_readdata = ram[rd_addr] ^ {31'h0, (flip1 && rd_addr == 1)};

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endfunction

    // Monitor: pops expectations whenever the DUT writes or pulses done.
    wr_t  wm;
    res_t rm;
    int   nrd = 0;
    always @(negedge clk) begin
        if (reset) begin
            nrd = 0;
        end else begin
            if (mem_chipselect && mem_write) begin
                if (wq.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_write: got addr %0d data 0x%0h, want no write",
                             mem_address, mem_writedata);
                end else begin
                    wm = wq.pop_front();
                    chk("wr_addr", 32'(mem_address), 32'(wm.addr));
                    chk("wr_data", mem_writedata, wm.data);
                    chk("wr_be", 32'(mem_byteenable), 32'(wm.be));
                    chk("wr_in_ready", 32'(in_ready), 32'd0);
                end
            end
            if (mem_chipselect && !mem_write) nrd++;
            if (done) begin
                if (rq.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_done: got done=1, want 0");
                end else begin
                    rm = rq.pop_front();
                    chk("done_word_count", 32'(word_count), 32'(rm.wc));
                    chk("done_err_overflow", 32'(err_overflow), 32'(rm.ovf));
                    chk("done_err_verify", 32'(err_verify), 32'(rm.ver));
                    chk("done_err_framing", 32'(err_framing), 32'(rm.frm));
                    chk("done_verify_reads", 32'(nrd), 32'(rm.nrd));
                    chk("done_busy", 32'(busy), 32'd1);
                end
                nrd = 0;
            end
        end
    end

    // Reference model: whole-packet view of what the loader must do.
    task automatic expect_packet(input logic [7:0] b[$], input bit frm, input bit flip);
        int   n   = b.size();
        int   nw  = (n + 3) / 4;
        int   wrn = (nw > CAP) ? CAP : nw;
        wr_t  e;
        res_t r;
        for (int w = 0; w < wrn; w++) begin
            e.addr = BASE + w;
            e.data = '0;
            e.be   = '0;
            for (int k = 0; k < 4; k++) begin
                if (w*4 + k < n) begin
                    e.data[k*8 +: 8] = b[w*4 + k];
                    e.be[k]          = 1'b1;
                end
            end
            wq.push_back(e);
        end
        r.wc  = wrn;
        r.ovf = (nw > CAP);
        r.nrd = r.ovf ? 0 : nw;
        r.ver = flip && !r.ovf && (nw >= 2);
        r.frm = frm;
        rq.push_back(r);
    endtask

    task automatic send_byte(input logic [7:0] d, input bit sop, input bit eop);
        int n = 0;
        bit r;
        in_data  = d;
        in_valid = 1'b1;
        in_sop   = sop;
        in_eop   = eop;
        forever begin
            @(negedge clk);
            r = in_ready;
            @(posedge clk);
            #1;
            if (r) break;
            n++;
            if (n > 200) begin
                total++; bad++;
                $display("FAIL send_timeout: got in_ready=0 for 200 cycles, want 1");
                break;
            end
        end
        in_valid = 1'b0;
        in_sop   = 1'b0;
        in_eop   = 1'b0;
        repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_packet(input logic [7:0] b[$]);
        for (int i = 0; i < b.size(); i++) begin
            send_byte(b[i], i == 0, i == b.size() - 1);
        end
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (rq.size() != 0 && n < 500) begin
            @(posedge clk);
            n++;
        end
        #1;
        if (n >= 500) begin
            total++; bad++;
            $display("FAIL %s_timeout: got no done pulse in 500 cycles, want done", name);
        end
        chk({name, "_busy_after"}, 32'(busy), 32'd0);
        chk({name, "_writes_left"}, 32'(wq.size()), 32'd0);
    endtask

    task automatic run_packet(input string name, input logic [7:0] b[$], input bit flip);
        flip1 = flip;
        expect_packet(b, 1'b0, flip);
        send_packet(b);
        wait_idle(name);
        flip1 = 1'b0;
    endtask

    logic [7:0] pkt[$];
    logic [7:0] pre[$];

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish, want finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset    = 1'b1;
        in_data  = '0;
        in_valid = 1'b0;
        in_sop   = 1'b0;
        in_eop   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_cs", 32'(mem_chipselect), 32'd0);
        chk("rst_write", 32'(mem_write), 32'd0);
        chk("rst_addr", 32'(mem_address), 32'd0);
        chk("rst_flags", 32'({done, err_overflow, err_verify, err_framing}), 32'd0);
        chk("rst_word_count", 32'(word_count), 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Stray byte without SOP in IDLE is ignored.
        send_byte(8'h5A, 1'b0, 1'b0);

        pkt = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        run_packet("full_word", pkt, 1'b0);

        pkt = {8'h11, 8'h12, 8'h13, 8'h14, 8'h15};
        run_packet("partial", pkt, 1'b0);

        pkt = {8'hAA};
        run_packet("single", pkt, 1'b0);

        pkt = {};
        for (int i = 0; i < 20; i++) pkt.push_back(8'(i + 8'h40));
        run_packet("overflow20", pkt, 1'b0);

        pkt = {};
        for (int i = 0; i < 23; i++) pkt.push_back(8'($urandom));
        run_packet("overflow_drain", pkt, 1'b0);

        pkt = {};
        for (int i = 0; i < 8; i++) pkt.push_back(8'($urandom));
        run_packet("verify_bad", pkt, 1'b1);

        // Flags and word_count clear on reset even from idle.
        reset = 1'b1;
        #2;
        chk("rst_idle_err_verify", 32'(err_verify), 32'd0);
        chk("rst_idle_word_count", 32'(word_count), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Framing: SOP after two bytes restarts the image at BASE.
        pre = {8'hC1, 8'hC2};
        pkt = {8'hD1, 8'hD2, 8'hD3, 8'hD4, 8'hD5, 8'hD6};
        expect_packet(pkt, 1'b1, 1'b0);
        send_byte(pre[0], 1'b1, 1'b0);
        send_byte(pre[1], 1'b0, 1'b0);
        send_packet(pkt);
        wait_idle("framing");

        // Reset mid-FILL: no write, no done, back to idle.
        send_byte(8'hE1, 1'b1, 1'b0);
        send_byte(8'hE2, 1'b0, 1'b0);
        send_byte(8'hE3, 1'b0, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_strobes", 32'({mem_chipselect, mem_write, done}), 32'd0);
        chk("midrst_flags", 32'({err_overflow, err_verify, err_framing}), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("midrst_no_done_pending", 32'(rq.size()), 32'd0);

        // Randomized packets, sometimes preceded by a stray non-SOP byte.
        for (int p = 0; p < 14; p++) begin
            int len;
            len = $urandom_range(1, 4 * CAP + 6);
            pkt = {};
            for (int i = 0; i < len; i++) pkt.push_back(8'($urandom));
            if ($urandom_range(0, 3) == 0) send_byte(8'($urandom), 1'b0, $urandom_range(0, 1) == 1);
            run_packet("random", pkt, $urandom_range(0, 4) == 0);
        end

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/platformniostimer_onchip_loader.md
# platformniostimer_onchip_loader

Byte-stream loader that sits directly upstream of the on-chip RAM's s1 slave port. It accepts an 8-bit Avalon-ST packet, packs bytes little-endian into 32-bit words with byteenables, and writes them to sequential word addresses. It then optionally reads the region back and compares an XOR checksum. It is used to load Nios code and data images without JTAG.

## Interface
Parameters:
- ADDR_W, 13, word-address width of the RAM.
- DEPTH, 8192, number of RAM words.
- BASE_ADDR, 0, first word address written.
- VERIFY_EN, 1, enables the readback-verify phase.

Ports:
- clk  in  1  single clock.
- reset  in  1  asynchronous, active-high reset.
- in_data  in  8  stream byte.
- in_valid  in  1  byte valid.
- in_startofpacket  in  1  first byte of image.
- in_endofpacket  in  1  last byte of image.
- in_ready  out  1  byte accepted when in_valid & in_ready.
- mem_address  out  ADDR_W  word address to RAM.
- mem_byteenable  out  4  byte lanes; bit0 = data[7:0].
- mem_chipselect  out  1  RAM access strobe.
- mem_write  out  1  write strobe, qualified by chipselect.
- mem_writedata  out  32  packed word.
- mem_readdata  in  32  RAM data, valid 1 cycle after address.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse at packet completion.
- err_overflow, err_verify, err_framing  out  1 each  sticky error flags.
- word_count  out  ADDR_W+1  words written in the current or last packet.

## Operation
States are IDLE, FILL, WRITE, DRAIN, VERIFY_RD, VERIFY_WAIT and DONE.
- **IDLE:** in_ready=1. Bytes without SOP are discarded. On an accepted SOP byte:
  - clear all errors, word_count, checksum and lane index;
  - place the byte in lane 0;
  - go to FILL, or to WRITE if EOP is also set.
- **FILL:** in_ready=1.
  - Each accepted byte goes to lane `idx`, its byteenable bit is set, and `idx` increments.
  - Go to WRITE after lane 3 is filled or on an EOP byte.
  - An accepted SOP byte in FILL sets err_framing, discards the partial word, and restarts at BASE_ADDR with this byte in lane 0. Previously written words are not undone.
- **WRITE:** in_ready=0 and mem_chipselect=mem_write=1 for exactly one cycle.
  - Unfilled lanes are written as 0 with their byteenable bit 0.
  - checksum ^= writedata masked by byteenable.
  - word_count and the address both increment.
  - Next state: FILL if not last; otherwise VERIFY_RD if VERIFY_EN, else DONE.
- **Overflow:** when the target address equals BASE_ADDR+word_count and word_count == DEPTH-BASE_ADDR, no write is issued. Instead err_overflow is set.
  - If the current word was last, go to DONE; otherwise go to DRAIN.
- **DRAIN:** in_ready=1 and all bytes are discarded until an EOP byte is accepted, then go to DONE.
- **VERIFY_RD:** mem_chipselect=1, mem_write=0, address = BASE_ADDR+vidx.
- **VERIFY_WAIT:** mem_readdata is masked and XORed into vsum.
  - The mask is 0xFFFFFFFF for all words except the final one, which uses the stored last byteenable.
  - After the last word, err_verify = (vsum != checksum) and the next state is DONE.
  - Otherwise vidx increments and the next state is VERIFY_RD.
  - Verify is skipped entirely if overflow occurred.
- **DONE:** done=1 for one cycle, then go to IDLE. The error flags and word_count hold until the next SOP is accepted.

## Timing
- **Reset values:** state IDLE, so in_ready=1 and busy=0. All mem_* outputs, done, all errors and word_count are 0.
- **Register outputs:** all mem_* outputs are registered state outputs, with no combinational path from in_* to mem_*.
- **Write throughput:**
  - A 4th byte accepted in cycle N produces the write strobe in cycle N+1, and in_ready returns in N+2.
  - Steady state is 4 bytes per 5 cycles.
- **Verify cost:** 2 cycles per word. RAM read latency is a fixed 1 cycle, with unregistered q.
- **Packet latency:** the last write is followed by 2·word_count verify cycles, then the done pulse.
- **Asynchronous reset mid-operation:**
  - all strobes deassert immediately and the partial word is lost;
  - no done pulse is produced;
  - the RAM contents already written remain.
- **Overlap:** a new packet is not accepted while busy. Bytes arriving during WRITE or VERIFY are back-pressured.

## Structure
- **Package `platformniostimer_loader_pkg`:**
  - state enum;
  - lane count (4);
  - constants for the full-word mask 4'hF and 32'hFFFFFFFF.
- **Sub-module `platformniostimer_loader_packer`:**
  - holds the lane index, data register and byteenable accumulation;
  - ports are clear, byte-accept, byte, word and byteenable.
- The FSM, address counter, checksum and verify logic live in the top module.

## Test plan
- **Full-word packet:** 8 bytes 01..08 with SOP on byte 0 and EOP on byte 7 → expect:
  - writes addr0=0x04030201 and addr1=0x08070605, both with be=F;
  - 2 verify reads;
  - done pulse, word_count=2, no errors.
- **Partial last word:** 5 bytes 11..15 → expect:
  - addr1 write of 0x00000015 with be=4'b0001;
  - verify passes, word_count=2.
- **Single byte:** one byte 0xAA with SOP+EOP → expect a single write at BASE_ADDR of 0x000000AA with be=1, then done.
- **Overflow:** DEPTH=4 with a 20-byte packet → expect:
  - 4 writes;
  - err_overflow=1;
  - in_ready held high until EOP;
  - done pulse with no verify reads.
- **Verify mismatch:** RAM model flips bit 0 of addr1 on readback → expect err_verify=1 and done pulse.
- **Framing and reset:**
  - SOP arriving after 2 bytes in FILL → err_framing=1 and the restart writes at BASE_ADDR.
  - reset asserted mid-FILL → no write, IDLE, all flags 0.
